// File: rtl/fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_ctrl                                                               |
// | Sequences a 1-cycle-latency instruction ROM into a 2-entry output buffer |
// | with valid/ready delivery, redirects and address-fault entries.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          MEMORY_SIZE = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        out_fault,
   output logic        rom_read_enable,
   output logic [31:0] rom_address,
   input  logic [31:0] rom_data_out
);

   localparam logic [31:0] c_num_words = 32'(MEMORY_SIZE / 32);
   localparam logic [31:0] c_nop       = 32'h0000_0013;

   logic [31:0] r_pc;
   logic [31:0] r_inflight_pc;
   logic        r_inflight;
   logic        r_halted;
   logic [31:0] r_fifo_pc    [2];
   logic [31:0] r_fifo_instr [2];
   logic        r_fifo_fault [2];
   logic        r_rd_ptr;
   logic        r_wr_ptr;
   logic [1:0]  r_count;

   logic        w_pop;
   logic [2:0]  w_occupancy;
   logic        w_pc_fault;
   logic        w_can_issue;
   logic        w_issue;
   logic        w_fault_push;
   logic        w_cap_push;
   logic        w_fault_idx;

   assign out_valid   = (r_count != 2'd0);
   assign w_pop       = out_valid && out_ready;
   // Slots that will still be claimed after this cycle's pop; capture lands next edge.
   assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_pc_fault  = (r_pc[1:0] != 2'b00) || ((r_pc >> 2) >= c_num_words);
   assign w_can_issue = !reset && !r_halted && !redirect_valid && (w_occupancy < 3'd2);
   assign w_issue     = w_can_issue && !w_pc_fault;
   assign w_fault_push = w_can_issue && w_pc_fault;
   assign w_cap_push  = !reset && !redirect_valid && r_inflight;
   // A fault can be pushed alongside a capture; the older capture goes first.
   assign w_fault_idx = r_wr_ptr ^ w_cap_push;

   assign rom_read_enable = w_issue;
   assign rom_address     = w_issue ? {2'b00, r_pc[31:2]} : 32'h0;

   assign out_pc    = out_valid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
   assign out_instr = out_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
   assign out_fault = out_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;

   always_ff @(posedge clk) begin
      if (w_cap_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
         r_fifo_instr[r_wr_ptr] <= rom_data_out;
         r_fifo_fault[r_wr_ptr] <= 1'b0;
      end
      if (w_fault_push) begin
         r_fifo_pc[w_fault_idx]    <= r_pc;
         r_fifo_instr[w_fault_idx] <= c_nop;
         r_fifo_fault[w_fault_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc          <= RESET_PC;
         r_inflight_pc <= 32'h0;
         r_inflight    <= 1'b0;
         r_halted      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_wr_ptr      <= 1'b0;
         r_count       <= 2'd0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
         r_halted   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'd4;
         end
         if (w_fault_push) begin
            r_halted <= 1'b1;
         end
         r_wr_ptr <= r_wr_ptr ^ (w_cap_push ^ w_fault_push);
         r_rd_ptr <= r_rd_ptr ^ w_pop;
         r_count  <= r_count + {1'b0, w_cap_push} + {1'b0, w_fault_push} - {1'b0, w_pop};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_ctrl                                                            |
// | Scoreboarded bench for fetch_ctrl with a behavioural 1-cycle ROM.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } entry_t;

   logic        clk            = 1'b0;
   logic        reset          = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        out_ready      = 1'b0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_fault;
   logic        rom_read_enable;
   logic [31:0] rom_address;
   logic [31:0] rom_q;
   logic [31:0] mem [0:31];

   entry_t exp_q[$];
   entry_t e;
   int     checks = 0;
   int     errors = 0;

   fetch_ctrl #(.RESET_PC(32'h0), .MEMORY_SIZE(1024)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_fault(out_fault),
      .rom_read_enable(rom_read_enable), .rom_address(rom_address),
      .rom_data_out(rom_q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_read_enable) rom_q <= mem[rom_address[4:0]];
   end

   function automatic logic [31:0] word(input int i);
      return (i < 4) ? 32'((i + 1) * 17) : (32'hC0DE_0000 | 32'(i));
   endfunction

   function automatic entry_t ok_entry(input logic [31:0] pc);
      entry_t t;
      t.pc    = pc;
      t.instr = word(int'(pc >> 2));
      t.fault = 1'b0;
      return t;
   endfunction

   // Scoreboard: every accepted head must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got pc=%h instr=%h fault=%b, none expected",
                     out_pc, out_instr, out_fault);
         end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr || out_fault !== e.fault) begin
               errors++;
               $display("FAIL sb_out: got pc=%h instr=%h fault=%b, want pc=%h instr=%h fault=%b",
                        out_pc, out_instr, out_fault, e.pc, e.instr, e.fault);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      out_ready      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 ||
          out_fault !== 1'b0 || rom_read_enable !== 1'b0 || rom_address !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b i=%h pc=%h f=%b en=%b a=%h, want all 0",
                  out_valid, out_instr, out_pc, out_fault, rom_read_enable, rom_address);
      end
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) exp_q.push_back(ok_entry(32'(i * 4)));
      #1;
      checks++;
      if (rom_read_enable !== 1'b1 || rom_address !== 32'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_c0: got en=%b a=%h v=%b, want en=1 a=0 v=0",
                  rom_read_enable, rom_address, out_valid);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0 || rom_address !== 32'd1) begin
         errors++;
         $display("FAIL basic_c1: got v=%b a=%h, want v=0 a=1", out_valid, rom_address);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h11) begin
         errors++;
         $display("FAIL basic_c2: got v=%b pc=%h i=%h, want v=1 pc=0 i=11",
                  out_valid, out_pc, out_instr);
      end
      repeat (4) tick();
      out_ready = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   task automatic test_stall();
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) exp_q.push_back(ok_entry(32'(i * 4)));
      tick();
      tick();
      for (int c = 3; c <= 6; c++) begin
         tick();
         out_ready = 1'b0;
         #1;
         checks++;
         if (rom_read_enable !== 1'b0 || out_valid !== 1'b1 ||
             out_pc !== 32'h4 || out_instr !== 32'h22) begin
            errors++;
            $display("FAIL stall_c%0d: got en=%b v=%b pc=%h i=%h, want en=0 v=1 pc=4 i=22",
                     c, rom_read_enable, out_valid, out_pc, out_instr);
         end
      end
      tick();
      out_ready = 1'b1;
      #1;
      checks++;
      if (rom_read_enable !== 1'b1 || rom_address !== 32'd3) begin
         errors++;
         $display("FAIL stall_resume: got en=%b a=%h, want en=1 a=3", rom_read_enable, rom_address);
      end
      repeat (4) tick();
      out_ready = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   task automatic test_redirect();
      do_reset();
      out_ready = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      exp_q.push_back(ok_entry(32'h10));
      exp_q.push_back(ok_entry(32'h14));
      #1;
      checks++;
      if (rom_read_enable !== 1'b0) begin
         errors++;
         $display("FAIL redir_noread: got en=%b, want 0", rom_read_enable);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (rom_read_enable !== 1'b1 || rom_address !== 32'd4 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_r1: got en=%b a=%h v=%b, want en=1 a=4 v=0",
                  rom_read_enable, rom_address, out_valid);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_r2: got v=%b, want 0", out_valid);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== word(4)) begin
         errors++;
         $display("FAIL redir_r3: got v=%b pc=%h i=%h, want v=1 pc=10 i=%h",
                  out_valid, out_pc, out_instr, word(4));
      end
      tick();
      tick();
      out_ready = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL redir_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   task automatic test_fault_end();
      entry_t f;
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h74;
      exp_q.push_back(ok_entry(32'h74));
      exp_q.push_back(ok_entry(32'h78));
      exp_q.push_back(ok_entry(32'h7C));
      f.pc = 32'h80; f.instr = 32'h13; f.fault = 1'b1;
      exp_q.push_back(f);
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (rom_read_enable !== 1'b1 || rom_address !== 32'd29) begin
         errors++;
         $display("FAIL end_first: got en=%b a=%h, want en=1 a=1d", rom_read_enable, rom_address);
      end
      repeat (5) tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_fault !== 1'b1) begin
         errors++;
         $display("FAIL end_fault: got v=%b pc=%h f=%b, want v=1 pc=80 f=1",
                  out_valid, out_pc, out_fault);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         checks++;
         if (rom_read_enable !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL end_halted%0d: got en=%b v=%b, want 0 0", k, rom_read_enable, out_valid);
         end
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      exp_q.push_back(ok_entry(32'h0));
      exp_q.push_back(ok_entry(32'h4));
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (rom_read_enable !== 1'b1 || rom_address !== 32'd0) begin
         errors++;
         $display("FAIL end_resume: got en=%b a=%h, want en=1 a=0", rom_read_enable, rom_address);
      end
      repeat (4) tick();
      out_ready = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL end_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   task automatic test_misaligned();
      entry_t f;
      do_reset();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h6;
      f.pc = 32'h6; f.instr = 32'h13; f.fault = 1'b1;
      exp_q.push_back(f);
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++;
      if (rom_read_enable !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mis_r1: got en=%b v=%b, want 0 0", rom_read_enable, out_valid);
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_instr !== 32'h13) begin
         errors++;
         $display("FAIL mis_r2: got v=%b f=%b i=%h, want v=1 f=1 i=13", out_valid, out_fault, out_instr);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         checks++;
         if (rom_read_enable !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_halted%0d: got en=%b v=%b, want 0 0", k, rom_read_enable, out_valid);
         end
      end
      out_ready = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mis_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      repeat (6) tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || rom_read_enable !== 1'b0 || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL mid_full: got v=%b en=%b pc=%h, want v=1 en=0 pc=0",
                  out_valid, rom_read_enable, out_pc);
      end
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(ok_entry(32'h0));
      exp_q.push_back(ok_entry(32'h4));
      #1;
      checks++;
      if (out_valid !== 1'b0 || rom_read_enable !== 1'b1 || rom_address !== 32'd0) begin
         errors++;
         $display("FAIL mid_after: got v=%b en=%b a=%h, want v=0 en=1 a=0",
                  out_valid, rom_read_enable, rom_address);
      end
      tick();
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h11) begin
         errors++;
         $display("FAIL mid_first: got v=%b pc=%h i=%h, want v=1 pc=0 i=11",
                  out_valid, out_pc, out_instr);
      end
      tick();
      tick();
      out_ready = 1'b0;
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_drain: got %0d left, want 0", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = word(i);
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_fault_end();
      test_misaligned();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller that sequences the synchronous-read instruction ROM (L1i) and delivers instructions, with their PCs, to the decode stage through a valid/ready handshake. It keeps a byte-addressed PC, converts it to the ROM's word index, and tracks the ROM's 1-cycle read latency with an in-flight flag. A 2-entry output buffer absorbs decode backpressure. It also handles redirects (branch/jump/trap) and address faults.

## Interface
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `MEMORY_SIZE`, 1024: must match the ROM instance; ROM word count NUM_WORDS = MEMORY_SIZE/32 (32 at default).
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  load a new PC this cycle.
- `redirect_pc`  in  32  redirect target, byte address.
- `out_valid`  out  1  head of buffer valid.
- `out_ready`  in  1  decode accepts head; transfer when `out_valid && out_ready`.
- `out_instr`  out  32  instruction word.
- `out_pc`  out  32  byte address of `out_instr`.
- `out_fault`  out  1  entry is an address fault, not a fetched instruction.
- `rom_read_enable`  out  1  to ROM `read_enable`.
- `rom_address`  out  32  to ROM `address`; word index = `pc >> 2`.
- `rom_data_out`  in  32  from ROM `data_out`; valid the cycle after a read.

## Operation
- State: `pc` (next fetch address), `inflight` + `inflight_pc`, 2-entry FIFO of {pc, instr, fault}, `halted`.
- Reset: `pc`=RESET_PC, FIFO empty, `inflight`=0, `halted`=0. All outputs 0.
- Issue condition: `!halted && !redirect_valid && (count + inflight - pop) < 2`, where pop = `out_valid && out_ready`. On issue: `rom_read_enable`=1, `rom_address`=`pc>>2`, `inflight_pc`<=`pc`, `pc`<=`pc+4` (mod 2^32), `inflight`<=1. Otherwise `rom_read_enable`=0 and `inflight`<=0.
- Fault check happens before issue: if `pc[1:0]`!=0 or `(pc>>2)` >= NUM_WORDS, no ROM read is made. Instead a fault entry {pc, 32'h0000_0013, fault=1} is pushed once the issue condition holds, and `halted`<=1. No further pushes or reads occur until a redirect.
- Capture: when `inflight`=1, push {`inflight_pc`, `rom_data_out`, 0} into the FIFO that cycle. Push and pop in the same cycle are both honoured. The FIFO never overflows because of the issue condition.
- Outputs: `out_*` show the FIFO head. When empty: `out_valid`=0 and `out_instr`/`out_pc`/`out_fault` = 0.
- Redirect (`redirect_valid`=1):
  - At the next edge: FIFO flushed, `inflight` data discarded (no push), `halted`<=0, `pc`<=`redirect_pc`.
  - No ROM read is issued in the redirect cycle.
  - A pop in the same cycle still counts as accepted by decode; flushing wins for the rest.
- Priority: `reset` > `redirect_valid` > capture/issue/pop.

## Timing
- First reset-free cycle = C0: read at RESET_PC issued in C0, captured at end of C1, `out_valid`=1 in C2.
- Steady state with `out_ready`=1: one instruction per cycle, consecutive PCs.
- Redirect asserted in cycle R: first read at `redirect_pc` in R+1, matching `out_valid` in R+3.
- Stall: at most 2 buffered entries. `rom_read_enable` drops while (count + inflight) = 2 with no pop. Fetch resumes in the same cycle a pop frees a slot. No loss or duplication.
- Reset mid-operation: all state cleared at the next edge. In-flight ROM data is ignored.

## Test plan
- ROM words 0..3 = 0x11, 0x22, 0x33, 0x44; RESET_PC=0; `out_ready`=1 -> `out_valid` rises in C2; outputs (pc, instr) = (0,0x11), (4,0x22), (8,0x33), (0xC,0x44) on consecutive cycles.
- Same setup with `out_ready`=0 for cycles C3–C6 -> head stays (4,0x22); `rom_read_enable`=0 once 2 entries are buffered; after release the stream continues at 8, 0xC with no gap or duplicate.
- `redirect_valid`=1, `redirect_pc`=0x10 while a read is in flight -> no read in the redirect cycle; old entries never appear; next output is (0x10, word 4) three cycles later.
- Sequential fetch from 0x74 at default MEMORY_SIZE -> outputs 0x74, 0x78, 0x7C, then (0x80, 0x13, fault=1); no further `rom_read_enable` until a redirect to 0 resumes normal fetch.
- Redirect to 0x6 -> single fault entry (pc 0x6, instr 0x13, fault=1); no ROM read issued.
- `reset` pulsed for one cycle mid-stream with a full FIFO -> `out_valid`=0 the next cycle; fetch restarts at RESET_PC with first output two cycles after reset deasserts.
